sram_byte_port: RTL

- Requester-side endpoint of the toggle req/ack SRAM handshake served by the SRAM arbiter; it drives one arbiter client port (the SPI port).
- Converts byte-stream commands (start byte address, length, direction) into single-byte SRAM transactions with auto-incrementing address.
- Write bytes arrive on a valid/ready stream; read bytes leave through a small FIFO on a valid/ready stream.

---
 rtl/sram_if_pkg.sv | 17 +
 rtl/sram_byte_fifo.sv | 48 ++++
 rtl/sram_byte_port.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/sram_if_pkg.sv
// sram_if_pkg: constants and state encoding shared by the SRAM arbiter and its client ports
package sram_if_pkg;

    localparam int SRAM_WORD_AW      = 18;
    localparam int SRAM_BYTE_AW      = 19;
    localparam int READ_WAIT_DEFAULT = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_GET,
        ST_RD_ISSUE,
        ST_WAIT_ACK,
        ST_RD_WAIT,
        ST_FIN
    } port_state_t;

endpackage

// File: rtl/sram_byte_fifo.sv
// sram_byte_fifo: synchronous byte FIFO; a push into a full FIFO is taken only alongside a pop
module sram_byte_fifo #(
    parameter int DEPTH = 2
) (
    input  logic                   clk200,
    input  logic                   reset,
    input  logic                   push,
    input  logic [7:0]             push_data,
    input  logic                   pop,
    output logic [7:0]             pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = count == (AW + 1)'(DEPTH);
    assign empty    = count == '0;
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk200) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
        end
    end

    // Byte storage, contents are don't-care until pushed
    always_ff @(posedge clk200) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/sram_byte_port.sv
// sram_byte_port: turns byte-stream commands into single-byte toggle req/ack SRAM accesses
module sram_byte_port
    import sram_if_pkg::*;
#(
    parameter int READ_WAIT     = READ_WAIT_DEFAULT,
    parameter int RD_FIFO_DEPTH = 2
) (
    input  logic                    clk200,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [SRAM_BYTE_AW-1:0] cmd_addr,
    input  logic [15:0]             cmd_len,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [7:0]              wr_data,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [7:0]              rd_data,
    output logic                    busy,
    output logic                    done,
    output logic                    sram_req,
    input  logic                    sram_ack,
    output logic                    sram_read,
    output logic [SRAM_WORD_AW-1:0] sram_address,
    output logic                    sram_ub,
    output logic [7:0]              sram_wdata,
    input  logic [15:0]             sram_rdata
);

    localparam int              FCW          = $clog2(RD_FIFO_DEPTH) + 1;
    localparam logic [FCW-1:0]  FIFO_DEPTH_C = FCW'(RD_FIFO_DEPTH);
    localparam logic [7:0]      WAIT_LOAD    = 8'(READ_WAIT - 1);

    port_state_t             state;
    port_state_t             state_nx;
    logic [SRAM_BYTE_AW-1:0] addr;
    logic [15:0]             remaining;
    logic                    is_write;
    logic [7:0]              wait_cnt;
    logic [FCW-1:0]          fifo_count;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    fifo_push;
    logic                    fifo_pop;
    logic                    rd_inflight;
    logic                    issue_wr;
    logic                    issue_rd;
    logic                    acked;

    assign acked       = sram_ack == sram_req;
    assign rd_inflight = !is_write && (state == ST_WAIT_ACK || state == ST_RD_WAIT);
    assign rd_valid    = !fifo_empty && !reset;
    assign fifo_pop    = rd_valid && rd_ready;

    // Next state, handshake outputs and the single-cycle issue/push strobes
    always_comb begin
        state_nx  = state;
        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
        done      = 1'b0;
        busy      = !reset && state != ST_IDLE;
        issue_wr  = 1'b0;
        issue_rd  = 1'b0;
        fifo_push = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = !reset;
                if (cmd_valid) state_nx = cmd_len == '0 ? ST_FIN : cmd_write ? ST_WR_GET : ST_RD_ISSUE;
            end
            ST_WR_GET: begin
                wr_ready = !reset;
                issue_wr = wr_valid;
                if (wr_valid) state_nx = ST_WAIT_ACK;
            end
            ST_RD_ISSUE: begin
                issue_rd = !fifo_full && (fifo_count + FCW'(rd_inflight)) < FIFO_DEPTH_C;
                if (issue_rd) state_nx = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (acked) state_nx = !is_write ? ST_RD_WAIT : remaining == 16'd1 ? ST_FIN : ST_WR_GET;
            end
            ST_RD_WAIT: begin
                fifo_push = wait_cnt == '0;
                if (fifo_push) state_nx = remaining == '0 ? ST_FIN : ST_RD_ISSUE;
            end
            ST_FIN: begin
                done     = !reset;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk200) begin
        state <= reset ? ST_IDLE : state_nx;
    end

    // Reset withdraws an unaccepted request and turns a racing acceptance into a read
    always_ff @(posedge clk200) begin
        if (reset) begin
            sram_req  <= sram_ack;
            sram_read <= 1'b1;
        end else begin
            if (state == ST_IDLE && cmd_valid) begin
                addr      <= cmd_addr;
                remaining <= cmd_len;
                is_write  <= cmd_write;
            end
            if (issue_wr || issue_rd) begin
                sram_req     <= ~sram_req;
                sram_read    <= issue_rd;
                sram_address <= addr[SRAM_BYTE_AW-1:1];
                sram_ub      <= ~addr[0];
            end
            if (issue_wr) sram_wdata <= wr_data;
            if (state == ST_WAIT_ACK && acked) begin
                addr      <= addr + SRAM_BYTE_AW'(1);
                remaining <= remaining - 16'd1;
                wait_cnt  <= WAIT_LOAD;
            end
            if (state == ST_RD_WAIT && wait_cnt != '0) wait_cnt <= wait_cnt - 8'd1;
        end
    end

    sram_byte_fifo #(
        .DEPTH(RD_FIFO_DEPTH)
    ) u_rd_fifo (
        .clk200   (clk200),
        .reset    (reset),
        .push     (fifo_push),
        .push_data(sram_ub ? sram_rdata[15:8] : sram_rdata[7:0]),
        .pop      (fifo_pop),
        .pop_data (rd_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

endmodule
